// File: rtl/bsg_mcl_axil_fifos_rx_mc.sv
// Multi-channel manycore-link AXI-Lite RX path: per-channel serializer + word buffer, round-robin merge.
// Optional macro BSG_MCL_AXIL_RX_PKT_LOCK_EN keeps the grant on one channel for a whole packet.
module bsg_mcl_axil_fifos_rx_mc #(
  parameter int unsigned fifo_width_p      = 128,
  parameter int unsigned axil_data_width_p = 32,
  parameter int unsigned req_credits_p     = 2,
  parameter int unsigned num_chan_p        = 2,
  localparam int unsigned ratio_lp  = fifo_width_p / axil_data_width_p,
  localparam int unsigned els_lp    = ratio_lp * req_credits_p,
  localparam int unsigned cred_w_lp = $clog2(els_lp + 1),
  localparam int unsigned chan_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_chan_p*fifo_width_p-1:0] fifo_req_i,
  input  logic [num_chan_p-1:0]             fifo_req_v_i,
  output logic [num_chan_p-1:0]             fifo_req_ready_o,
  output logic [axil_data_width_p-1:0]      axil_req_o,
  output logic                              axil_req_v_o,
  input  logic                              axil_req_ready_i,
  output logic [chan_w_lp-1:0]              axil_req_chan_o,
  output logic                              axil_req_last_o,
  output logic [num_chan_p*cred_w_lp-1:0]   req_credits_o
);

  localparam int unsigned cnt_w_lp  = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
  localparam int unsigned ptr_w_lp  = (els_lp > 1) ? $clog2(els_lp) : 1;
  localparam int unsigned word_w_lp = axil_data_width_p + 1;

  if ((fifo_width_p % axil_data_width_p) != 0 || fifo_width_p < axil_data_width_p) begin : g_width_chk
    $fatal(1, "fifo_width_p must be a multiple of axil_data_width_p");
  end

  logic                         en_q, en_d;
  logic [num_chan_p-1:0]        busy_q, busy_d;
  logic [cnt_w_lp-1:0]          cnt_q  [num_chan_p];
  logic [cnt_w_lp-1:0]          cnt_d  [num_chan_p];
  logic [fifo_width_p-1:0]      pkt_q  [num_chan_p];
  logic [fifo_width_p-1:0]      pkt_d  [num_chan_p];
  logic [word_w_lp-1:0]         mem_q  [num_chan_p][els_lp];
  logic [word_w_lp-1:0]         mem_d  [num_chan_p][els_lp];
  logic [ptr_w_lp-1:0]          wptr_q [num_chan_p];
  logic [ptr_w_lp-1:0]          wptr_d [num_chan_p];
  logic [ptr_w_lp-1:0]          rptr_q [num_chan_p];
  logic [ptr_w_lp-1:0]          rptr_d [num_chan_p];
  logic [cred_w_lp-1:0]         occ_q  [num_chan_p];
  logic [cred_w_lp-1:0]         occ_d  [num_chan_p];
  logic [chan_w_lp-1:0]         rr_q, rr_d;
  logic                         hold_q, hold_d;
  logic [chan_w_lp-1:0]         hold_chan_q, hold_chan_d;
`ifdef BSG_MCL_AXIL_RX_PKT_LOCK_EN
  logic                         lock_q, lock_d;
  logic [chan_w_lp-1:0]         lock_chan_q, lock_chan_d;
`endif

  logic [num_chan_p-1:0]        full_c, nonempty_c, enq_c, deq_c, ready_c;
  logic [word_w_lp-1:0]         wdata_c [num_chan_p];
  logic [chan_w_lp-1:0]         pick_c, grant_c;
  logic                         valid_c, xfer_c;
  logic [word_w_lp-1:0]         head_c;

  // Serializer: an idle channel pushes word 0 straight from the input on accept.
  always_comb begin : ser_comb
    logic is_last;
    is_last = 1'b0;
    en_d    = 1'b1;
    busy_d  = busy_q;
    enq_c   = '0;
    ready_c = '0;
    for (int unsigned c = 0; c < num_chan_p; c++) begin
      full_c[c]     = (occ_q[c] == cred_w_lp'(els_lp));
      nonempty_c[c] = (occ_q[c] != '0);
      cnt_d[c]      = cnt_q[c];
      pkt_d[c]      = pkt_q[c];
      if (busy_q[c]) begin
        is_last    = (cnt_q[c] == cnt_w_lp'(ratio_lp - 1));
        enq_c[c]   = ~full_c[c];
        wdata_c[c] = {is_last, pkt_q[c][32'(cnt_q[c]) * axil_data_width_p +: axil_data_width_p]};
        ready_c[c] = en_q & enq_c[c] & is_last;
        if (enq_c[c]) begin
          cnt_d[c] = is_last ? '0 : cnt_q[c] + cnt_w_lp'(1);
          if (is_last) busy_d[c] = 1'b0;
        end
      end else begin
        ready_c[c] = en_q;
        wdata_c[c] = {(ratio_lp == 1), fifo_req_i[c*fifo_width_p +: axil_data_width_p]};
      end
      if (ready_c[c] && fifo_req_v_i[c]) begin
        pkt_d[c] = fifo_req_i[c*fifo_width_p +: fifo_width_p];
        if (busy_q[c] || full_c[c]) begin
          cnt_d[c]  = '0;
          busy_d[c] = 1'b1;
        end else begin
          enq_c[c]  = 1'b1;
          cnt_d[c]  = (ratio_lp > 1) ? cnt_w_lp'(1) : '0;
          busy_d[c] = (ratio_lp > 1);
        end
      end
    end
  end

  // Round-robin pick; a stalled grant is frozen so the offered word stays stable.
  always_comb begin : arb_comb
    int unsigned idx;
    logic        found;
    idx     = 0;
    found   = 1'b0;
    pick_c  = rr_q;
    for (int unsigned i = 0; i < num_chan_p; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= num_chan_p) idx = idx - num_chan_p;
      if (!found && nonempty_c[chan_w_lp'(idx)]) begin
        pick_c = chan_w_lp'(idx);
        found  = 1'b1;
      end
    end
    grant_c = hold_q ? hold_chan_q : pick_c;
    valid_c = |nonempty_c;
`ifdef BSG_MCL_AXIL_RX_PKT_LOCK_EN
    if (lock_q) begin
      grant_c = lock_chan_q;
      valid_c = nonempty_c[lock_chan_q];
    end
`endif
    xfer_c  = valid_c & axil_req_ready_i;
    head_c  = mem_q[grant_c][rptr_q[grant_c]];
    rr_d    = rr_q;
    if (xfer_c) rr_d = (grant_c == chan_w_lp'(num_chan_p - 1)) ? '0 : grant_c + chan_w_lp'(1);
    hold_d      = valid_c & ~axil_req_ready_i;
    hold_chan_d = grant_c;
`ifdef BSG_MCL_AXIL_RX_PKT_LOCK_EN
    lock_d      = xfer_c ? ~head_c[axil_data_width_p] : lock_q;
    lock_chan_d = xfer_c ? grant_c : lock_chan_q;
`endif
  end

  // Per-channel circular word buffers.
  always_comb begin : buf_comb
    mem_d = mem_q;
    for (int unsigned c = 0; c < num_chan_p; c++) begin
      deq_c[c]  = xfer_c & (grant_c == chan_w_lp'(c));
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      occ_d[c]  = occ_q[c];
      if (enq_c[c]) begin
        mem_d[c][wptr_q[c]] = wdata_c[c];
        wptr_d[c] = (wptr_q[c] == ptr_w_lp'(els_lp - 1)) ? '0 : wptr_q[c] + ptr_w_lp'(1);
      end
      if (deq_c[c]) begin
        rptr_d[c] = (rptr_q[c] == ptr_w_lp'(els_lp - 1)) ? '0 : rptr_q[c] + ptr_w_lp'(1);
      end
      case ({enq_c[c], deq_c[c]})
        2'b10:   occ_d[c] = occ_q[c] + cred_w_lp'(1);
        2'b01:   occ_d[c] = occ_q[c] - cred_w_lp'(1);
        default: occ_d[c] = occ_q[c];
      endcase
    end
  end

  always_comb begin : out_comb
    req_credits_o    = '0;
    fifo_req_ready_o = ready_c;
    axil_req_v_o     = valid_c;
    axil_req_o       = valid_c ? head_c[axil_data_width_p-1:0] : '0;
    axil_req_last_o  = valid_c & head_c[axil_data_width_p];
    axil_req_chan_o  = (num_chan_p > 1 && valid_c) ? grant_c : '0;
    for (int unsigned c = 0; c < num_chan_p; c++) begin
      req_credits_o[c*cred_w_lp +: cred_w_lp] = cred_w_lp'(els_lp) - occ_q[c];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      en_q        <= 1'b0;
      busy_q      <= '0;
      rr_q        <= '0;
      hold_q      <= 1'b0;
      hold_chan_q <= '0;
`ifdef BSG_MCL_AXIL_RX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
`endif
      for (int unsigned c = 0; c < num_chan_p; c++) begin
        cnt_q[c]  <= '0;
        pkt_q[c]  <= '0;
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        occ_q[c]  <= '0;
      end
    end else begin
      en_q        <= en_d;
      busy_q      <= busy_d;
      rr_q        <= rr_d;
      hold_q      <= hold_d;
      hold_chan_q <= hold_chan_d;
`ifdef BSG_MCL_AXIL_RX_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
`endif
      for (int unsigned c = 0; c < num_chan_p; c++) begin
        cnt_q[c]  <= cnt_d[c];
        pkt_q[c]  <= pkt_d[c];
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        occ_q[c]  <= occ_d[c];
      end
    end
  end

  // Storage array needs no reset: occupancy gates everything read from it.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule
